// File: rtl/jtvigil_sdram_resp.sv
// jtvigil_sdram_resp
// Fixed-latency word-memory responder standing in for the SDRAM controller.
// It serves two kinds of clients on one memory port:
//  - four game-side ROM banks (ba*_addr/ba_rd -> ba_ack/ba_dst/ba_dok/ba_rdy/data_read)
//  - the download port (prog_we writes and prog_rd readbacks).
// One access is in flight at a time. Every access starts from IDLE, and its
// rdy cycle is the last cycle of the busy state.
// Cycle counter cnt (0 = entry cycle) within each busy state:
//  WR : cnt 0 ack + mem_wr, cnt 1 prog_rdy
//  PRD: cnt 0 ack + mem_rd, cnt MEM_LAT prog_rdy with the read word
//  RD : cnt 0 ack, mem_rd for cnt < BURST, word i on data_read at cnt MEM_LAT+i
// BURST must be 1..4 and MEM_LAT 1..7, so cnt never exceeds 10 and fits in 4 bits.

module jtvigil_sdram_resp #(
    parameter int BURST   = 2,
    parameter int MEM_LAT = 2
) (
    input  logic        rst,
    input  logic        clk,
    input  logic        downloading,
    input  logic [21:0] ba0_addr,
    input  logic [21:0] ba1_addr,
    input  logic [21:0] ba2_addr,
    input  logic [21:0] ba3_addr,
    input  logic [3:0]  ba_rd,
    output logic [3:0]  ba_ack,
    output logic [3:0]  ba_dst,
    output logic [3:0]  ba_dok,
    output logic [3:0]  ba_rdy,
    output logic [15:0] data_read,
    input  logic [21:0] prog_addr,
    input  logic [15:0] prog_data,
    input  logic [1:0]  prog_mask,
    input  logic [1:0]  prog_ba,
    input  logic        prog_we,
    input  logic        prog_rd,
    output logic        prog_ack,
    output logic        prog_rdy,
    output logic [23:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [15:0] mem_din,
    output logic [1:0]  mem_mask,
    input  logic [15:0] mem_dout
);

    typedef enum logic [1:0] {
        IDLE,
        WR,
        RD,
        PRD
    } state_t;

    // Counter thresholds in the counter's own width.
    localparam logic [3:0] BURST_N = 4'(BURST);
    localparam logic [3:0] LAT_N   = 4'(MEM_LAT);
    localparam logic [3:0] LAST_N  = 4'(MEM_LAT + BURST - 1);
    localparam logic [3:0] WR_LAST = 4'd1;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;

    // Round-robin bookkeeping and the granted bank burst.
    logic [1:0]  ptr;
    logic [1:0]  gnt;
    logic [21:0] base_addr;

    // Download request captured at its grant.
    logic [23:0] prog_addr_q;
    logic [15:0] prog_data_q;
    logic [1:0]  prog_mask_q;

    // Last word shown on data_read, held between accesses.
    logic [15:0] data_hold;
    logic        capture;

    // Arbitration helpers.
    logic [7:0]  rd_dbl;
    logic [3:0]  rd_rot;
    logic [1:0]  rr_ofs;
    logic [1:0]  rr_bank;
    logic [21:0] rr_addr;
    logic [21:0] rd_word_addr;

    // Round-robin pick: rotate requests so the pointer bank sits at bit 0,
    // take the lowest set bit, then rotate the offset back to a bank number.
    // NOTE: every signal gets a default at the top of a combinational block, so no path can leave it unassigned and infer a latch.
    always_comb begin
        rd_dbl  = {ba_rd, ba_rd};
        rd_rot  = rd_dbl[{1'b0, ptr} +: 4];
        rr_ofs  = 2'd3;
        if (rd_rot[0]) begin
            rr_ofs = 2'd0;
        end else if (rd_rot[1]) begin
            rr_ofs = 2'd1;
        end else if (rd_rot[2]) begin
            rr_ofs = 2'd2;
        end
        rr_bank = ptr + rr_ofs;
        rr_addr = ba0_addr;
        case (rr_bank)
            2'd0: rr_addr = ba0_addr;
            2'd1: rr_addr = ba1_addr;
            2'd2: rr_addr = ba2_addr;
            2'd3: rr_addr = ba3_addr;
        endcase
    end

    // State register and per-state cycle counter (cleared on entering or leaving IDLE).
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            if (state == IDLE || state_nxt == IDLE) begin
                cnt <= 4'd0;
            end else begin
                cnt <= cnt + 4'd1;
            end
        end
    end

    // Next state: IDLE priority prog_we > prog_rd > bank reads; busy states end after their rdy cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (prog_we) begin
                    state_nxt = WR;
                end else if (prog_rd) begin
                    state_nxt = PRD;
                end else if (!downloading && (ba_rd != 4'd0)) begin
                    state_nxt = RD;
                end
            end
            WR: begin
                if (cnt == WR_LAST) state_nxt = IDLE;
            end
            RD: begin
                if (cnt == LAST_N) state_nxt = IDLE;
            end
            PRD: begin
                if (cnt == LAT_N) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Grant-time latches (bank, burst base, pointer, download request) and the data_read hold register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr         <= 2'd0;
            gnt         <= 2'd0;
            base_addr   <= 22'd0;
            prog_addr_q <= 24'd0;
            prog_data_q <= 16'd0;
            prog_mask_q <= 2'd0;
            data_hold   <= 16'd0;
        end else begin
            if (state == IDLE && state_nxt == RD) begin
                gnt       <= rr_bank;
                ptr       <= rr_bank + 2'd1;
                base_addr <= rr_addr;
            end
            if (state == IDLE && (state_nxt == WR || state_nxt == PRD)) begin
                prog_addr_q <= {prog_ba, prog_addr};
                prog_data_q <= prog_data;
                prog_mask_q <= prog_mask;
            end
            if (capture) begin
                data_hold <= mem_dout;
            end
        end
    end

    // Outputs decoded from state and cycle counter; data_read passes mem_dout through on capture cycles.
    always_comb begin
        ba_ack       = 4'd0;
        ba_dst       = 4'd0;
        ba_dok       = 4'd0;
        ba_rdy       = 4'd0;
        prog_ack     = 1'b0;
        prog_rdy     = 1'b0;
        mem_addr     = 24'd0;
        mem_rd       = 1'b0;
        mem_wr       = 1'b0;
        mem_din      = 16'd0;
        mem_mask     = 2'd0;
        capture      = 1'b0;
        // Burst address wraps within the 22-bit word space; bank bits come from gnt.
        rd_word_addr = base_addr + 22'(cnt);
        case (state)
            WR: begin
                if (cnt == 4'd0) begin
                    prog_ack = 1'b1;
                    mem_wr   = 1'b1;
                    mem_addr = prog_addr_q;
                    mem_din  = prog_data_q;
                    mem_mask = prog_mask_q;
                end else begin
                    prog_rdy = 1'b1;
                end
            end
            PRD: begin
                if (cnt == 4'd0) begin
                    prog_ack = 1'b1;
                    mem_rd   = 1'b1;
                    mem_addr = prog_addr_q;
                end
                if (cnt == LAT_N) begin
                    prog_rdy = 1'b1;
                    capture  = 1'b1;
                end
            end
            RD: begin
                if (cnt == 4'd0) begin
                    ba_ack[gnt] = 1'b1;
                end
                if (cnt < BURST_N) begin
                    mem_rd   = 1'b1;
                    mem_addr = {gnt, rd_word_addr};
                end
                if (cnt >= LAT_N) begin
                    capture     = 1'b1;
                    ba_dok[gnt] = 1'b1;
                    if (cnt == LAT_N)  ba_dst[gnt] = 1'b1;
                    if (cnt == LAST_N) ba_rdy[gnt] = 1'b1;
                end
            end
            default: ;
        endcase
        data_read = capture ? mem_dout : data_hold;
    end

endmodule

// File: tb/tb_jtvigil_sdram_resp.sv
// tb_jtvigil_sdram_resp
// Directed sequence plus randomized bank/download traffic. The bench owns the
// word memory (fixed MEM_LAT read latency, byte-masked writes) and predicts
// every strobe, address and data word from the responder's documented timing:
// grant one cycle after the IDLE request, word i on data_read MEM_LAT cycles
// after its mem_rd, one IDLE cycle between accesses.
// Inputs are driven and outputs sampled at the falling edge.

module tb_jtvigil_sdram_resp;

    localparam int BURST   = 2;
    localparam int MEM_LAT = 2;
    localparam int LAST    = MEM_LAT + BURST - 1;

    logic        rst;
    logic        clk;
    logic        downloading;
    logic [21:0] ba_addr [4];
    logic [3:0]  ba_rd;
    logic [3:0]  ba_ack;
    logic [3:0]  ba_dst;
    logic [3:0]  ba_dok;
    logic [3:0]  ba_rdy;
    logic [15:0] data_read;
    logic [21:0] prog_addr;
    logic [15:0] prog_data;
    logic [1:0]  prog_mask;
    logic [1:0]  prog_ba;
    logic        prog_we;
    logic        prog_rd;
    logic        prog_ack;
    logic        prog_rdy;
    logic [23:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] mem_din;
    logic [1:0]  mem_mask;
    logic [15:0] mem_dout;

    int          n_checks;
    int          n_fail;
    logic [1:0]  ptr_model;
    logic [15:0] last_word;

    // Bench-side memory: sparse contents over a deterministic fill pattern.
    logic [15:0] mem [logic [23:0]];
    logic [15:0] rd_pipe [MEM_LAT];

    jtvigil_sdram_resp #(.BURST(BURST), .MEM_LAT(MEM_LAT)) dut (
        .rst        (rst),
        .clk        (clk),
        .downloading(downloading),
        .ba0_addr   (ba_addr[0]),
        .ba1_addr   (ba_addr[1]),
        .ba2_addr   (ba_addr[2]),
        .ba3_addr   (ba_addr[3]),
        .ba_rd      (ba_rd),
        .ba_ack     (ba_ack),
        .ba_dst     (ba_dst),
        .ba_dok     (ba_dok),
        .ba_rdy     (ba_rdy),
        .data_read  (data_read),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .prog_mask  (prog_mask),
        .prog_ba    (prog_ba),
        .prog_we    (prog_we),
        .prog_rd    (prog_rd),
        .prog_ack   (prog_ack),
        .prog_rdy   (prog_rdy),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem_din    (mem_din),
        .mem_mask   (mem_mask),
        .mem_dout   (mem_dout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] mem_word(input logic [23:0] a);
        if (mem.exists(a)) return mem[a];
        return {a[7:0] ^ a[23:16], a[15:8] ^ 8'hA5};
    endfunction

    function automatic logic [15:0] apply_mask(input logic [15:0] old, input logic [15:0] din,
                                               input logic [1:0] mask);
        logic [15:0] r;
        r = old;
        if (!mask[0]) r[7:0]  = din[7:0];
        if (!mask[1]) r[15:8] = din[15:8];
        return r;
    endfunction

    // Memory write port.
    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr] = apply_mask(mem_word(mem_addr), mem_din, mem_mask);
    end

    // Memory read port: word valid MEM_LAT cycles after the mem_rd cycle.
    always @(posedge clk) begin
        rd_pipe[0] <= mem_rd ? mem_word(mem_addr) : 16'hDEAD;
        for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_dout = rd_pipe[MEM_LAT-1];

    // Spec-level round robin: first requesting bank from the pointer upward, wrapping.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] p);
        for (int i = 0; i < 4; i++) begin
            if (req[(int'(p) + i) % 4]) return 2'((int'(p) + i) % 4);
        end
        return p;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, " strobes"}, {ba_ack, ba_dst, ba_dok, ba_rdy}, 32'h0);
        check({tag, " data_read"}, data_read, 32'h0);
        check({tag, " ctl"}, {prog_ack, prog_rdy, mem_rd, mem_wr, mem_mask}, 32'h0);
        check({tag, " mem_addr"}, mem_addr, 32'h0);
        check({tag, " mem_din"}, mem_din, 32'h0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, " strobes"}, {ba_ack, ba_dst, ba_dok, ba_rdy}, 32'h0);
        check({tag, " ctl"}, {prog_ack, prog_rdy, mem_rd, mem_wr}, 32'h0);
        check({tag, " hold"}, data_read, last_word);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        tick();
        check_zero("reset");
        tick();
        rst       = 1'b0;
        ptr_model = 2'd0;
        last_word = 16'h0;
    endtask

    // Called at the grant cycle of bank g; ends at the rdy cycle.
    task automatic run_burst(input logic [1:0] g, input bit drop);
        logic [21:0] base;
        logic [3:0]  one, ea, ed, eo, er;
        logic [15:0] expw;
        base = ba_addr[g];
        one  = 4'b0001 << g;
        for (int k = 0; k <= LAST; k++) begin
            ea = (k == 0)       ? one : 4'b0;
            ed = (k == MEM_LAT) ? one : 4'b0;
            eo = (k >= MEM_LAT) ? one : 4'b0;
            er = (k == LAST)    ? one : 4'b0;
            check($sformatf("burst g%0d k%0d strobes", g, k), {ba_ack, ba_dst, ba_dok, ba_rdy},
                  {16'h0, ea, ed, eo, er});
            check($sformatf("burst g%0d k%0d mem_rd", g, k), mem_rd, (k < BURST) ? 1 : 0);
            check($sformatf("burst g%0d k%0d prog", g, k), {prog_ack, prog_rdy, mem_wr}, 32'h0);
            if (k < BURST)
                check($sformatf("burst g%0d k%0d mem_addr", g, k), mem_addr, {g, base + 22'(k)});
            if (k >= MEM_LAT) begin
                expw = mem_word({g, base + 22'(k - MEM_LAT)});
                check($sformatf("burst g%0d k%0d data", g, k), data_read, expw);
                last_word = expw;
            end
            // The address was latched at grant; moving it now must not disturb the burst.
            if (k == 0) ba_addr[g] = 22'($urandom);
            if (k == LAST) begin
                if (drop) ba_rd[g] = 1'b0;
            end else begin
                tick();
            end
        end
        ptr_model = g + 2'd1;
    endtask

    // Called at an IDLE cycle; ends at the prog_rdy cycle.
    task automatic prog_write(input logic [1:0] ba, input logic [21:0] addr,
                              input logic [15:0] data, input logic [1:0] mask);
        prog_ba   = ba;
        prog_addr = addr;
        prog_data = data;
        prog_mask = mask;
        prog_we   = 1'b1;
        tick();
        check("pw entry ctl", {prog_ack, prog_rdy, mem_wr, mem_rd}, 32'b1010);
        check("pw mem_addr", mem_addr, {ba, addr});
        check("pw mem_din", mem_din, data);
        check("pw mem_mask", mem_mask, mask);
        check("pw entry strobes", {ba_ack, ba_dst, ba_dok, ba_rdy}, 32'h0);
        tick();
        check("pw rdy ctl", {prog_ack, prog_rdy, mem_wr, mem_rd}, 32'b0100);
        check("pw rdy strobes", {ba_ack, ba_dst, ba_dok, ba_rdy}, 32'h0);
        prog_we = 1'b0;
    endtask

    task automatic prog_read(input logic [1:0] ba, input logic [21:0] addr);
        logic [15:0] expw;
        prog_ba   = ba;
        prog_addr = addr;
        prog_rd   = 1'b1;
        tick();
        check("pr entry ctl", {prog_ack, prog_rdy, mem_wr, mem_rd}, 32'b1001);
        check("pr mem_addr", mem_addr, {ba, addr});
        for (int k = 1; k <= MEM_LAT; k++) begin
            tick();
            check("pr strobes", {ba_ack, ba_dst, ba_dok, ba_rdy}, 32'h0);
            if (k < MEM_LAT) begin
                check("pr wait ctl", {prog_ack, prog_rdy, mem_wr, mem_rd}, 32'h0);
            end else begin
                check("pr rdy ctl", {prog_ack, prog_rdy, mem_wr, mem_rd}, 32'b0100);
                expw = mem_word({ba, addr});
                check("pr data", data_read, expw);
                last_word = expw;
                prog_rd   = 1'b0;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0]  g;
        logic [15:0] old, data, keep, expw;
        logic [21:0] a;
        logic [1:0]  b, m;

        n_checks    = 0;
        n_fail      = 0;
        rst         = 1'b1;
        downloading = 1'b0;
        ba_rd       = 4'd0;
        for (int i = 0; i < 4; i++) ba_addr[i] = 22'd0;
        prog_addr   = 22'd0;
        prog_data   = 16'd0;
        prog_mask   = 2'd0;
        prog_ba     = 2'd0;
        prog_we     = 1'b0;
        prog_rd     = 1'b0;
        ptr_model   = 2'd0;
        last_word   = 16'h0;

        // T1: single bank-0 burst from preloaded words.
        mem[24'h000100] = 16'hA5A5;
        mem[24'h000101] = 16'h5A5A;
        reset_dut();
        ba_addr[0] = 22'h100;
        ba_rd      = 4'b0001;
        tick();
        run_burst(2'd0, 1'b1);
        check("t1 last word", last_word, 32'h5A5A);
        tick();
        check_idle("t1 idle");

        // T2: all four banks held, grant order 0,1,2,3 from a fresh pointer.
        reset_dut();
        for (int i = 0; i < 4; i++) ba_addr[i] = 22'($urandom);
        ba_rd = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            tick();
            run_burst(2'(i), 1'b1);
            tick();
            check_idle("t2 idle");
        end
        ba_rd = 4'b1001;
        tick();
        run_burst(2'd0, 1'b1);
        tick();
        check_idle("t2 reraise idle");
        tick();
        run_burst(2'd3, 1'b1);
        tick();
        check_idle("t2 tail idle");

        // T5: burst wraps the 22-bit word address, bank bits untouched.
        ba_addr[1] = 22'h3FFFFF;
        ba_rd      = 4'b0010;
        tick();
        run_burst(2'd1, 1'b1);
        tick();
        check_idle("t5 idle");

        // downloading rising mid-burst lets the current burst finish.
        ba_rd = 4'b0100;
        tick();
        downloading = 1'b1;
        run_burst(2'd2, 1'b1);
        tick();
        check_idle("dl mid idle");
        downloading = 1'b0;

        // Random bank traffic: every requester held until served.
        repeat (40) begin
            for (int i = 0; i < 4; i++) ba_addr[i] = 22'($urandom);
            if ($urandom_range(0, 3) == 0) ba_addr[$urandom_range(0, 3)] = 22'h3FFFFF;
            ba_rd = 4'($urandom_range(1, 15));
            while (ba_rd != 4'd0) begin
                g = rr_pick(ba_rd, ptr_model);
                tick();
                run_burst(g, 1'b1);
                tick();
                check_idle("rand idle");
            end
        end

        // T3: downloading blocks bank reads; masked write then readback.
        downloading = 1'b1;
        ba_addr[0]  = 22'($urandom);
        ba_rd       = 4'b0001;
        old = mem_word(24'hC00010);
        prog_write(2'd3, 22'h000010, 16'h1234, 2'b01);
        check("t3 high byte only", mem_word(24'hC00010), {8'h12, old[7:0]});
        repeat (4) begin
            tick();
            check_idle("t3 blocked");
        end
        prog_read(2'd3, 22'h000010);
        tick();
        check_idle("t3 idle");
        repeat (12) begin
            a    = 22'($urandom);
            b    = 2'($urandom);
            m    = 2'($urandom);
            data = 16'($urandom);
            old  = mem_word({b, a});
            keep = {{8{m[1]}}, {8{m[0]}}};
            expw = (old & keep) | (data & ~keep);
            prog_write(b, a, data, m);
            check("rand write word", mem_word({b, a}), expw);
            tick();
            check_idle("rand write idle");
            prog_read(b, a);
            check("rand readback", data_read, expw);
            tick();
            check_idle("rand read idle");
        end
        downloading = 1'b0;
        tick();
        run_burst(2'd0, 1'b1);
        tick();
        check_idle("t3 release idle");

        // T4: write and bank 2 in the same IDLE cycle; write goes first.
        ba_rd = 4'b0100;
        prog_write(2'd1, 22'($urandom), 16'($urandom), 2'b00);
        tick();
        check_idle("t4 idle");
        tick();
        run_burst(2'd2, 1'b1);
        tick();
        check_idle("t4 tail idle");

        // Simultaneous prog_we and prog_rd: write served, then read of the same word.
        a       = 22'($urandom);
        prog_rd = 1'b1;
        prog_write(2'd2, a, 16'hBEEF, 2'b00);
        tick();
        check_idle("we+rd idle");
        prog_read(2'd2, a);
        check("we+rd readback", data_read, 32'hBEEF);
        tick();
        check_idle("we+rd tail idle");

        // prog_rd ahead of a pending bank read.
        ba_rd = 4'b1000;
        prog_read(2'd0, 22'($urandom));
        tick();
        check_idle("prd>bank idle");
        tick();
        run_burst(2'd3, 1'b1);
        tick();
        check_idle("prd>bank tail idle");

        // T6: reset one cycle after ba_ack[3] aborts the burst and clears the pointer.
        ba_rd = 4'b1000;
        tick();
        check("t6 ack", ba_ack, 32'b1000);
        ba_rd = 4'b0000;
        rst   = 1'b1;
        tick();
        rst       = 1'b0;
        ptr_model = 2'd0;
        last_word = 16'h0;
        for (int k = 0; k < LAST + 2; k++) begin
            tick();
            check_zero("t6 after reset");
        end
        for (int i = 0; i < 4; i++) ba_addr[i] = 22'($urandom);
        ba_rd = 4'b1111;
        tick();
        run_burst(2'd0, 1'b1);
        while (ba_rd != 4'd0) begin
            tick();
            check_idle("t6 idle");
            g = rr_pick(ba_rd, ptr_model);
            tick();
            run_burst(g, 1'b1);
        end
        tick();
        check_idle("t6 final idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
